// File: rtl/trng_health_pkg.sv
// Shared types, default cutoffs and helpers for the TRNG online health tests.
package trng_health_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STARTUP = 2'd1,
    RUN     = 2'd2,
    ALARM   = 2'd3
  } state_e;

  localparam int unsigned RCT_WARN_DEF   = 10;
  localparam int unsigned RCT_FAIL_DEF   = 13;
  localparam int unsigned APT_CUTOFF_DEF = 589;

  // Increment val, saturating at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

endpackage

// File: rtl/trng_health_monitor_apt.sv
// Adaptive proportion test over non-overlapping windows of W_SIZE valid bits.
module trng_apt_window #(
  parameter int unsigned W_SIZE    = 1024,
  parameter int unsigned APT_CNT_W = $clog2(W_SIZE) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic                 bit_i,
  input  logic [APT_CNT_W-1:0] cutoff_i,
  output logic                 win_end_o,
  output logic                 fail_o
);

  localparam int unsigned IDX_W = $clog2(W_SIZE);

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 ref_q, ref_d;
  logic [APT_CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic                 last;

  always_comb begin
    idx_d    = idx_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    cnt_next = cnt_q;
    last     = (idx_q == IDX_W'(W_SIZE - 1));
    // The first bit of a window becomes the reference and counts as its own match.
    if (idx_q == '0) begin
      cnt_next = APT_CNT_W'(1);
    end else if (bit_i == ref_q) begin
      cnt_next = cnt_q + APT_CNT_W'(1);
    end
    if (valid_i) begin
      idx_d = idx_q + IDX_W'(1);
      cnt_d = cnt_next;
      if (idx_q == '0) ref_d = bit_i;
    end
    win_end_o = valid_i && last && !clr_i;
    fail_o    = win_end_o && (cutoff_i != '0) && (cnt_next >= cutoff_i);
    if (clr_i) begin
      idx_d = '0;
      ref_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      ref_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      ref_q <= ref_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trng_health_monitor.sv
// TRNG online health monitor: repetition count test, adaptive proportion test,
// startup/run/alarm sequencing, sticky alarm and saturating event counters.
module trng_health_monitor
  import trng_health_pkg::*;
#(
  parameter int unsigned W_SIZE          = 1024,
  parameter int unsigned RCT_CNT_W       = 6,
  parameter int unsigned APT_CNT_W       = $clog2(W_SIZE) + 1,
  parameter int unsigned EVT_CNT_W       = 16,
  parameter int unsigned STARTUP_WINDOWS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic [RCT_CNT_W-1:0] rct_warn_cutoff,
  input  logic [RCT_CNT_W-1:0] rct_fail_cutoff,
  input  logic [APT_CNT_W-1:0] apt_cutoff,
  input  logic                 clear_alarm,
  output logic                 rct_warn,
  output logic                 rct_fail,
  output logic                 apt_fail,
  output logic                 alarm,
  output logic                 startup_done,
  output logic [EVT_CNT_W-1:0] rct_fail_cnt,
  output logic [EVT_CNT_W-1:0] apt_fail_cnt
);

  localparam int unsigned SU_W = (STARTUP_WINDOWS > 1) ? $clog2(STARTUP_WINDOWS) : 1;

  state_e               state_q, state_d;
  logic                 from_run_q, from_run_d;
  logic [SU_W-1:0]      su_cnt_q, su_cnt_d;
  logic [RCT_CNT_W-1:0] run_len_q, run_len_d, new_len;
  logic                 prev_q, prev_d, have_q, have_d;
  logic                 rct_warn_q, rct_warn_d, rct_fail_q, rct_fail_d, apt_fail_q, apt_fail_d;
  logic                 alarm_q, alarm_d;
  logic [EVT_CNT_W-1:0] rct_cnt_q, rct_cnt_d, apt_cnt_q, apt_cnt_d;
  logic                 same, sat_hold, tst, fail_evt, apt_restart, apt_clr, win_end;

  assign fail_evt    = rct_fail_q || apt_fail_q;
  assign apt_restart = (state_q == ALARM) && clear_alarm && !fail_evt && !from_run_q;
  assign apt_clr     = !en || apt_restart;

  trng_apt_window #(
    .W_SIZE   (W_SIZE),
    .APT_CNT_W(APT_CNT_W)
  ) u_apt (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (apt_clr),
    .valid_i  (bit_valid),
    .bit_i    (bit_in),
    .cutoff_i (apt_cutoff),
    .win_end_o(win_end),
    .fail_o   (apt_fail_d)
  );

  // A saturated run holds its length, so it must not re-match a cutoff.
  always_comb begin
    tst       = en && bit_valid;
    same      = have_q && (bit_in == prev_q);
    sat_hold  = same && (run_len_q == '1);
    new_len   = same ? RCT_CNT_W'(sat_inc(32'(run_len_q), RCT_CNT_W)) : RCT_CNT_W'(1);
    rct_warn_d = tst && !sat_hold && (rct_warn_cutoff != '0) && (new_len == rct_warn_cutoff);
    rct_fail_d = tst && !sat_hold && (rct_fail_cutoff != '0) && (new_len == rct_fail_cutoff);
    run_len_d = run_len_q;
    prev_d    = prev_q;
    have_d    = have_q;
    if (!en) begin
      run_len_d = '0;
      prev_d    = 1'b0;
      have_d    = 1'b0;
    end else if (bit_valid) begin
      run_len_d = new_len;
      prev_d    = bit_in;
      have_d    = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    from_run_d = from_run_q;
    su_cnt_d   = '0;
    unique case (state_q)
      IDLE:    state_d = STARTUP;
      STARTUP: begin
        su_cnt_d = su_cnt_q;
        if (fail_evt) begin
          state_d    = ALARM;
          from_run_d = 1'b0;
        end else if (win_end && !rct_fail_d && !apt_fail_d) begin
          if (su_cnt_q == SU_W'(STARTUP_WINDOWS - 1)) state_d = RUN;
          else su_cnt_d = su_cnt_q + SU_W'(1);
        end
      end
      RUN: begin
        if (fail_evt) begin
          state_d    = ALARM;
          from_run_d = 1'b1;
        end
      end
      ALARM: begin
        if (clear_alarm && !fail_evt) state_d = from_run_q ? RUN : STARTUP;
      end
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  // Clear happens first so a coincident fail leaves the alarm set and a count of one.
  always_comb begin
    alarm_d   = (alarm_q && !clear_alarm) || fail_evt;
    rct_cnt_d = clear_alarm ? '0 : rct_cnt_q;
    apt_cnt_d = clear_alarm ? '0 : apt_cnt_q;
    if (rct_fail_q) rct_cnt_d = EVT_CNT_W'(sat_inc(32'(rct_cnt_d), EVT_CNT_W));
    if (apt_fail_q) apt_cnt_d = EVT_CNT_W'(sat_inc(32'(apt_cnt_d), EVT_CNT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      from_run_q <= 1'b0;
      su_cnt_q   <= '0;
      run_len_q  <= '0;
      prev_q     <= 1'b0;
      have_q     <= 1'b0;
      rct_warn_q <= 1'b0;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
      alarm_q    <= 1'b0;
      rct_cnt_q  <= '0;
      apt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      from_run_q <= from_run_d;
      su_cnt_q   <= su_cnt_d;
      run_len_q  <= run_len_d;
      prev_q     <= prev_d;
      have_q     <= have_d;
      rct_warn_q <= rct_warn_d;
      rct_fail_q <= rct_fail_d;
      apt_fail_q <= apt_fail_d;
      alarm_q    <= alarm_d;
      rct_cnt_q  <= rct_cnt_d;
      apt_cnt_q  <= apt_cnt_d;
    end
  end

  assign rct_warn     = rct_warn_q;
  assign rct_fail     = rct_fail_q;
  assign apt_fail     = apt_fail_q;
  assign alarm        = alarm_q;
  assign startup_done = (state_q == RUN) || ((state_q == ALARM) && from_run_q);
  assign rct_fail_cnt = rct_cnt_q;
  assign apt_fail_cnt = apt_cnt_q;

endmodule

// File: tb/tb_trng_health_monitor.sv
// Randomised and directed bench for trng_health_monitor against a bit-history reference model.
module tb_trng_health_monitor;
  import trng_health_pkg::*;

  localparam int unsigned W   = 1024;
  localparam int unsigned SUW = 1;

  logic        clk = 1'b0;
  logic        rst_n, en, bit_valid, bit_in, clear_alarm;
  logic [5:0]  rct_warn_cutoff, rct_fail_cutoff;
  logic [10:0] apt_cutoff;
  logic        rct_warn, rct_fail, apt_fail, alarm, startup_done;
  logic [15:0] rct_fail_cnt, apt_fail_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int seen_warn, seen_rfail, seen_afail;

  // reference model: bit histories and the observable consequences of events
  state_e m_mode;
  bit     m_from_run, m_alarm;
  int     m_clean, m_rcnt, m_acnt;
  bit     e_warn, e_rfail, e_afail;
  bit     rct_hist[$];
  bit     win_bits[$];

  trng_health_monitor #(
    .W_SIZE         (W),
    .RCT_CNT_W      (6),
    .APT_CNT_W      (11),
    .EVT_CNT_W      (16),
    .STARTUP_WINDOWS(SUW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .bit_valid      (bit_valid),
    .bit_in         (bit_in),
    .rct_warn_cutoff(rct_warn_cutoff),
    .rct_fail_cutoff(rct_fail_cutoff),
    .apt_cutoff     (apt_cutoff),
    .clear_alarm    (clear_alarm),
    .rct_warn       (rct_warn),
    .rct_fail       (rct_fail),
    .apt_fail       (apt_fail),
    .alarm          (alarm),
    .startup_done   (startup_done),
    .rct_fail_cnt   (rct_fail_cnt),
    .apt_fail_cnt   (apt_fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = IDLE; m_from_run = 0; m_alarm = 0; m_clean = 0;
    m_rcnt = 0; m_acnt = 0; e_warn = 0; e_rfail = 0; e_afail = 0;
    rct_hist.delete(); win_bits.delete();
  endtask

  // Trailing run of equal bits; longer than any 6-bit cutoff once it exceeds 63.
  function automatic int trailing_run();
    int n = 0;
    for (int i = rct_hist.size() - 1; i >= 0; i--) begin
      if (rct_hist[i] != rct_hist[rct_hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step(input bit en_v, input bit v, input bit b, input bit clr);
    bit fe, restart, win_done, nw, nrf, naf;
    int run, ones;
    fe = e_rfail | e_afail;
    restart = 0; win_done = 0; nw = 0; nrf = 0; naf = 0;
    if (clr) begin m_rcnt = 0; m_acnt = 0; end
    if (e_rfail && m_rcnt < 65535) m_rcnt++;
    if (e_afail && m_acnt < 65535) m_acnt++;
    m_alarm = (m_alarm && !clr) || fe;
    if (!en_v) begin
      rct_hist.delete(); win_bits.delete();
    end else begin
      restart = (m_mode == ALARM) && clr && !fe && !m_from_run;
      if (v) begin
        rct_hist.push_back(b);
        if (rct_hist.size() > 70) void'(rct_hist.pop_front());
        run = trailing_run();
        nw  = (rct_warn_cutoff != 0) && (run == int'(rct_warn_cutoff));
        nrf = (rct_fail_cutoff != 0) && (run == int'(rct_fail_cutoff));
        if (!restart) begin
          win_bits.push_back(b);
          if (win_bits.size() == W) begin
            ones = 0;
            foreach (win_bits[i]) if (win_bits[i] == win_bits[0]) ones++;
            naf = (apt_cutoff != 0) && (ones >= int'(apt_cutoff));
            win_done = 1;
            win_bits.delete();
          end
        end
      end
      if (restart) win_bits.delete();
    end
    if (!en_v) m_mode = IDLE;
    else case (m_mode)
      IDLE: begin m_mode = STARTUP; m_clean = 0; end
      STARTUP: begin
        if (fe) begin m_mode = ALARM; m_from_run = 0; end
        else if (win_done && !nrf && !naf) begin
          m_clean++;
          if (m_clean >= SUW) m_mode = RUN;
        end
      end
      RUN: if (fe) begin m_mode = ALARM; m_from_run = 1; end
      ALARM: if (clr && !fe) begin
        if (m_from_run) m_mode = RUN;
        else begin m_mode = STARTUP; m_clean = 0; end
      end
      default: m_mode = IDLE;
    endcase
    e_warn = nw; e_rfail = nrf; e_afail = naf;
  endtask

  task automatic check_outputs();
    bit su;
    su = (m_mode == RUN) || (m_mode == ALARM && m_from_run);
    chk("rct_warn", 32'(rct_warn), 32'(e_warn));
    chk("rct_fail", 32'(rct_fail), 32'(e_rfail));
    chk("apt_fail", 32'(apt_fail), 32'(e_afail));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("startup_done", 32'(startup_done), 32'(su));
    chk("rct_fail_cnt", 32'(rct_fail_cnt), 32'(m_rcnt));
    chk("apt_fail_cnt", 32'(apt_fail_cnt), 32'(m_acnt));
    if (rct_warn === 1'b1) seen_warn++;
    if (rct_fail === 1'b1) seen_rfail++;
    if (apt_fail === 1'b1) seen_afail++;
  endtask

  task automatic step(input bit en_v, input bit v, input bit b, input bit clr);
    en = en_v; bit_valid = v; bit_in = b; clear_alarm = clr;
    @(posedge clk);
    #1;
    model_step(en_v, v, b, clr);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; bit_valid = 0; bit_in = 0; clear_alarm = 0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic tally_clear();
    seen_warn = 0; seen_rfail = 0; seen_afail = 0;
  endtask

  task automatic set_defaults();
    rct_warn_cutoff = 6'(RCT_WARN_DEF);
    rct_fail_cutoff = 6'(RCT_FAIL_DEF);
    apt_cutoff      = 11'(APT_CUTOFF_DEF);
  endtask

  initial begin
    int nvalid;
    bit v;
    set_defaults();
    tally_clear();
    do_reset();

    // all-ones stream
    tally_clear();
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("t1_warn_pulses", 32'(seen_warn), 1);
    chk("t1_fail_pulses", 32'(seen_rfail), 1);
    chk("t1_alarm", 32'(alarm), 1);
    chk("t1_startup_done", 32'(startup_done), 0);

    // alternating window passes startup
    do_reset();
    tally_clear();
    for (int i = 0; i < 1024; i++) step(1, 1, (i % 2) == 0, 0);
    chk("t2_startup_done", 32'(startup_done), 1);
    chk("t2_apt_pulses", 32'(seen_afail), 0);

    // APT boundary with RCT disabled
    rct_warn_cutoff = '0; rct_fail_cutoff = '0;
    tally_clear();
    for (int i = 0; i < 1024; i++) step(1, 1, i < 589, 0);
    step(1, 0, 0, 0);
    chk("t3_apt_pulses", 32'(seen_afail), 1);
    chk("t3_apt_cnt", 32'(apt_fail_cnt), 1);
    chk("t3_alarm", 32'(alarm), 1);
    step(1, 0, 0, 1);
    chk("t3_cleared", 32'(alarm), 0);
    tally_clear();
    for (int i = 0; i < 1024; i++) step(1, 1, i < 588, 0);
    step(1, 0, 0, 0);
    chk("t3b_apt_pulses", 32'(seen_afail), 0);
    chk("t3b_rct_pulses", 32'(seen_rfail + seen_warn), 0);

    // clear coincident with a fresh rct_fail while alarmed from RUN
    set_defaults();
    for (int i = 0; i < 13; i++) step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    chk("t4_alarm_set", 32'(alarm), 1);
    for (int i = 0; i < 13; i++) step(1, 1, 0, 0);
    chk("t4_fail_pulse", 32'(rct_fail), 1);
    step(1, 0, 0, 1);
    chk("t4_alarm_kept", 32'(alarm), 1);
    chk("t4_rct_cnt", 32'(rct_fail_cnt), 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("t4_alarm_clr", 32'(alarm), 0);
    chk("t4_back_in_run", 32'(startup_done), 1);

    // en drop and async reset mid-window
    for (int i = 0; i < 300; i++) step(1, 1, 1'($urandom_range(1)), 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 200; i++) step(1, 1, 1'($urandom_range(1)), 0);
    do_reset();
    chk("t5_rct_cnt_zero", 32'(rct_fail_cnt), 0);
    chk("t5_apt_cnt_zero", 32'(apt_fail_cnt), 0);

    // sparse valid, all-zero stream
    tally_clear();
    nvalid = 0;
    while (nvalid < 40) begin
      v = ($urandom_range(99) < 30);
      step(1, v, 0, 0);
      if (v) nvalid++;
    end
    step(1, 0, 0, 0);
    chk("t6_warn_pulses", 32'(seen_warn), 1);
    chk("t6_fail_pulses", 32'(seen_rfail), 1);

    // random traffic, live cutoff changes, occasional clear and disable
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        rct_warn_cutoff = 6'($urandom_range(12));
        rct_fail_cutoff = 6'($urandom_range(15));
        apt_cutoff      = ($urandom_range(9) == 0) ? '0 : 11'($urandom_range(600, 500));
      end
      step($urandom_range(199) != 0, $urandom_range(99) < 70,
           $urandom_range(99) < 55, $urandom_range(99) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trng_health_monitor.md
Name: trng_health_monitor

Overview:
- Synthesisable online health-test engine for the RO-based TRNG bitstream. Sits directly after the sampling flip-flop (`random_bit`) and before any post-processing or FIFO.
- Implements NIST SP 800-90B repetition count test (RCT) and adaptive proportion test (APT).
- RCT has two alarm levels (warn and fail). All cutoffs are runtime-programmable, and the APT window size is parametrised.
- Includes a startup phase, a sticky alarm, and saturating event counters for software readout.

Parameters:
- W_SIZE, 1024, APT window length in bits; power of 2, minimum 16.
- RCT_CNT_W, 6, width of the RCT run-length counter and the RCT cutoff inputs.
- APT_CNT_W, $clog2(W_SIZE)+1, width of the APT counter and the APT cutoff input.
- EVT_CNT_W, 16, width of the saturating failure-event counters.
- STARTUP_WINDOWS, 1, number of full APT windows that must pass before entering RUN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  test enable; low forces IDLE
- bit_valid  in  1  bit_in is a new sample this cycle
- bit_in  in  1  raw TRNG bit
- rct_warn_cutoff  in  RCT_CNT_W  run length that raises a warning (default 10)
- rct_fail_cutoff  in  RCT_CNT_W  run length that raises a failure (default 13)
- apt_cutoff  in  APT_CNT_W  APT failure threshold (default 589)
- clear_alarm  in  1  clears the sticky alarm and both event counters
- rct_warn  out  1  one-cycle pulse
- rct_fail  out  1  one-cycle pulse
- apt_fail  out  1  one-cycle pulse
- alarm  out  1  sticky OR of all fail events
- startup_done  out  1  high in RUN, or in ALARM when ALARM was entered from RUN
- rct_fail_cnt  out  EVT_CNT_W  saturating count of rct_fail events
- apt_fail_cnt  out  EVT_CNT_W  saturating count of apt_fail events

Behaviour:
- Reset values: all outputs are 0, state is IDLE, and all internal counters are 0.
- States:
  - IDLE: entered when en=0. Run and window counters are cleared; event counters and alarm are held.
  - IDLE->STARTUP when en=1.
  - STARTUP->RUN after STARTUP_WINDOWS consecutive APT windows with no rct_fail and no apt_fail.
  - Any fail event in STARTUP or RUN -> ALARM.
  - ALARM->RUN on clear_alarm, but only if the fail that caused ALARM occurred in RUN; otherwise ALARM->STARTUP.
  - en=0 in any state -> IDLE (takes priority).
- Only bit_valid cycles advance the tests. Tests keep running in ALARM so the event counters keep accumulating.
- RCT:
  - The first valid bit after IDLE sets run_len=1.
  - If the bit equals the previous bit, run_len increments, saturating at all-ones. Otherwise run_len returns to 1.
  - rct_warn pulses in the cycle after run_len becomes equal to rct_warn_cutoff; rct_fail is the same against rct_fail_cutoff.
  - Each fires at most once per run. The comparison is equality on the incremented value, so a saturated run never re-fires.
- APT:
  - The first valid bit of each window is the reference and sets count=1; each later bit equal to the reference increments count.
  - After the W_SIZE-th bit, apt_fail pulses in the next cycle if count >= apt_cutoff.
  - The next window starts with the next valid bit (no overlap).
- Latency: all pulses are registered, asserting exactly 1 clk after the triggering bit_valid cycle.
- RCT and APT pulses may coincide in the same cycle. Each event counter then increments independently.
- Event counters saturate at 2^EVT_CNT_W-1.
- Alarm set has priority over clear: if clear_alarm and a fail pulse occur in the same cycle, alarm stays 1 and the counters are cleared and then incremented by that event (final value 1).
- Cutoff value 0 disables that test; no pulse is ever produced.
- Cutoffs are sampled live; changing them mid-window affects only later comparisons.
- Asynchronous reset mid-window discards all partial state immediately.

Decomposition:
- Package trng_health_pkg:
  - state enum (IDLE, STARTUP, RUN, ALARM)
  - default cutoff constants RCT_WARN_DEF=10, RCT_FAIL_DEF=13, APT_CUTOFF_DEF=589
  - a saturating-increment function
- Sub-module trng_apt_window: window bit counter, reference register, match counter, end-of-window compare, parametrised by W_SIZE.
- The RCT logic and the FSM stay in the top.

Test Plan:
- All-ones stream, 20 valid bits, defaults:
  - rct_warn pulses 1 clk after bit 10 and rct_fail 1 clk after bit 13, once each.
  - State goes STARTUP->ALARM and alarm=1.
- Alternating 1010..., 1024 bits, W_SIZE=1024:
  - count=512, so there is no apt_fail.
  - startup_done rises 1 clk after bit 1024.
- Window with reference 1 followed by 588 more ones then zeros (589 ones total):
  - apt_fail pulses 1 clk after bit 1024 and apt_fail_cnt=1.
  - Repeat with 588 ones total: no pulse.
- Alarm raised in RUN, then clear_alarm coincident with a new rct_fail:
  - alarm stays 1 and rct_fail_cnt=1.
  - A later clear_alarm alone gives alarm=0 and state RUN.
- Mid-window: en=0 for 1 cycle, then rst_n low mid-window:
  - run_len and the window count restart.
  - No spurious pulses occur.
  - With en=0 the event counters are held; after reset they are 0.
- bit_valid toggled randomly at 30% duty with an all-zero stream:
  - Pulses occur only after the 10th and 13th valid bits, independent of idle cycles.
